// File: rtl/bist_pkg.sv
// bist_pkg
//   Shared definitions for the BIST response-compaction slice: default
//   widths and the controller FSM state encoding.
//   No ports.
package bist_pkg;

    localparam int DEF_N     = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        CHECK = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/misr_reg.sv
// misr_reg
//   n-bit multiple-input signature register in right-shift Galois form.
//   Ports:
//     clk, rst  clock and asynchronous active-high reset (sig clears to 0)
//     load      load seed into the register (has priority over upd)
//     seed      initial signature value
//     upd       fold resp into the signature this cycle
//     poly      feedback taps
//     resp      response word to compact
//     sig       current signature
module misr_reg #(
    parameter int n = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [n-1:0] seed,
    input  logic         upd,
    input  logic [n-1:0] poly,
    input  logic [n-1:0] resp,
    output logic [n-1:0] sig
);

    logic [n-1:0] next_sig;

    // sig[0] is the bit shifted out; it feeds back into the MSB and into
    // every lower stage whose tap is set.
    always_comb begin
        next_sig = '0;
        for (int i = 0; i < n - 1; i++) begin
            next_sig[i] = (sig[0] & poly[i]) ^ sig[i+1] ^ resp[i];
        end
        next_sig[n-1] = sig[0] ^ resp[n-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sig <= '0;
        end else if (load) begin
            sig <= seed;
        end else if (upd) begin
            sig <= next_sig;
        end
    end

endmodule

// File: rtl/bist_misr_ctrl.sv
// bist_misr_ctrl
//   BIST response-compaction controller. Reloads and enables the upstream
//   pattern generator, compacts num_pat valid CUT responses into a MISR
//   and compares the final signature against golden.
//   Ports:
//     clk, rst     clock and asynchronous active-high reset
//     start        begin a session (only honoured in IDLE or DONE)
//     num_pat      number of responses to compact (sampled in LOAD)
//     poly         MISR feedback taps
//     seed         MISR initial value (sampled in LOAD)
//     golden       expected signature (sampled in CHECK)
//     resp_valid   resp holds a valid response this cycle
//     resp         CUT response word
//     gen_rst      one-cycle generator reload pulse
//     lfsr_en      generator advance enable
//     busy         session in progress
//     done         result valid
//     pass         signature matched golden (meaningful when done)
//     signature    current MISR contents (only with MISR_SIG_OUT_EN defined)
//   Optional feature macro: MISR_SIG_OUT_EN
module bist_misr_ctrl
    import bist_pkg::*;
#(
    parameter int n     = DEF_N,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_pat,
    input  logic [n-1:0]     poly,
    input  logic [n-1:0]     seed,
    input  logic [n-1:0]     golden,
    input  logic             resp_valid,
    input  logic [n-1:0]     resp,
    output logic             gen_rst,
    output logic             lfsr_en,
    output logic             busy,
    output logic             done,
    output logic             pass
`ifdef MISR_SIG_OUT_EN
    ,
    output logic [n-1:0]     signature
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt;
    logic             pass_r;
    logic [n-1:0]     sig;
    logic             sig_load, sig_upd;

    assign sig_load = (state == LOAD);
    assign sig_upd  = (state == RUN) && resp_valid;

    misr_reg #(.n(n)) u_misr (
        .clk  (clk),
        .rst  (rst),
        .load (sig_load),
        .seed (seed),
        .upd  (sig_upd),
        .poly (poly),
        .resp (resp),
        .sig  (sig)
    );

`ifdef MISR_SIG_OUT_EN
    assign signature = sig;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // RUN is left on the response that brings the count down from 1, so
    // the counter never has to pass through zero.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = LOAD;
            LOAD:    next_state = (num_pat == '0) ? CHECK : RUN;
            RUN:     if (resp_valid && (cnt == CNT_ONE)) next_state = CHECK;
            CHECK:   next_state = DONE;
            DONE:    if (start) next_state = LOAD;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gen_rst = 1'b0;
        lfsr_en = 1'b0;
        busy    = 1'b0;
        done    = 1'b0;
        pass    = 1'b0;
        case (state)
            LOAD: begin
                gen_rst = 1'b1;
                busy    = 1'b1;
            end
            RUN: begin
                lfsr_en = 1'b1;
                busy    = 1'b1;
            end
            CHECK: begin
                busy = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                pass = pass_r;
            end
            default: ;
        endcase
    end

    // Remaining-response counter and the registered compare result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            pass_r <= 1'b0;
        end else begin
            if (state == LOAD) begin
                cnt <= num_pat;
            end else if (sig_upd && (cnt != '0)) begin
                cnt <= cnt - CNT_ONE;
            end
            if (state == CHECK) begin
                pass_r <= (sig == golden);
            end
        end
    end

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// tb_bist_misr_ctrl
//   Self-checking bench for bist_misr_ctrl. An event-timed reference model
//   (cycle numbers of the reload and check phases, responses still owed,
//   arithmetic signature fold) predicts every output each cycle; directed
//   sessions pin the model with hand-computed signatures and latencies, and
//   randomized sessions follow.
//   Optional feature macro: MISR_SIG_OUT_EN (adds signature checks).
module tb_bist_misr_ctrl;

    localparam int N  = 8;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_pat;
    logic [N-1:0]  poly, seed, golden, resp;
    logic          resp_valid;
    logic          gen_rst, lfsr_en, busy, done, pass;
`ifdef MISR_SIG_OUT_EN
    logic [N-1:0]  signature;
`endif

    int checks = 0;
    int passes = 0;

    bist_misr_ctrl #(.n(N), .CNT_W(CW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .num_pat    (num_pat),
        .poly       (poly),
        .seed       (seed),
        .golden     (golden),
        .resp_valid (resp_valid),
        .resp       (resp),
        .gen_rst    (gen_rst),
        .lfsr_en    (lfsr_en),
        .busy       (busy),
        .done       (done),
        .pass       (pass)
`ifdef MISR_SIG_OUT_EN
        ,
        .signature  (signature)
`endif
    );

    always #5 clk = ~clk;

    // Reference model state: cycle index of the current clock interval,
    // the interval that is the reload cycle and the one that is the check
    // cycle, whether responses are being accepted, and the result.
    int           cyc         = 0;
    int           loadCyc     = -1;
    int           checkCyc    = -1;
    int           remaining   = 0;
    bit           inRun       = 1'b0;
    bit           resultReady = 1'b0;
    bit           mpass       = 1'b0;
    logic [N-1:0] msig        = '0;
    bit           mAtLoad, mAtCheck, mIdle;

    // Right-shift Galois step: shift, fold the response in, and if the
    // outgoing bit was set XOR in the taps with the MSB always fed back.
    function automatic logic [N-1:0] fold(input logic [N-1:0] s,
                                          input logic [N-1:0] r,
                                          input logic [N-1:0] p);
        logic [N-1:0] taps;
        taps = {1'b1, p[N-2:0]};
        return (s >> 1) ^ r ^ (s[0] ? taps : '0);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc         = 0;
            loadCyc     = -1;
            checkCyc    = -1;
            remaining   = 0;
            inRun       = 1'b0;
            resultReady = 1'b0;
            mpass       = 1'b0;
            msig        = '0;
        end else begin
            mAtLoad  = (cyc == loadCyc);
            mAtCheck = (cyc == checkCyc);
            mIdle    = !mAtLoad && !inRun && !mAtCheck;
            if (mIdle && start) begin
                loadCyc     = cyc + 1;
                resultReady = 1'b0;
            end else if (mAtLoad) begin
                msig      = seed;
                remaining = int'(num_pat);
                if (remaining == 0) checkCyc = cyc + 1;
                else                inRun    = 1'b1;
            end else if (inRun && resp_valid) begin
                msig = fold(msig, resp, poly);
                remaining--;
                if (remaining == 0) begin
                    inRun    = 1'b0;
                    checkCyc = cyc + 1;
                end
            end else if (mAtCheck) begin
                mpass       = (msig == golden);
                resultReady = 1'b1;
            end
            cyc++;
        end
    end

    function automatic logic [4:0] outVec();
        return {gen_rst, lfsr_en, busy, done, pass};
    endfunction

    function automatic logic [4:0] expVec();
        logic l, c;
        l = (cyc == loadCyc);
        c = (cyc == checkCyc);
        return {l, inRun, l | inRun | c, resultReady, resultReady & mpass};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        checkOutput("cycleOuts", 32'(outVec()), 32'(expVec()));
`ifdef MISR_SIG_OUT_EN
        checkOutput("cycleSig", 32'(signature), 32'(msig));
`endif
    end

    // Directed session: vpat gives resp_valid per RUN cycle (bit 0 first).
    task automatic runDirected(input string tag, input logic [N-1:0] s,
                               input logic [N-1:0] p, input int np,
                               input logic [N-1:0] g, input logic [N-1:0] r,
                               input logic [7:0] vpat,
                               input logic [N-1:0] expSig,
                               input logic expPass, input int expLfsr);
        int idx, genCnt, lfsrCnt, lat, ticks;
        bit finished, wasLast;
        seed = s; poly = p; num_pat = CW'(np); golden = g; resp = r;
        resp_valid = 1'b0;
        start = 1'b1;
        tick();
        start   = 1'b0;
        genCnt  = int'(gen_rst);
        lfsrCnt = int'(lfsr_en);
        idx = 0; lat = -1; ticks = 0; finished = 1'b0;
        for (int c = 0; c < 100 && !finished; c++) begin
            wasLast = 1'b0;
            if (inRun) begin
                resp_valid = (idx < 8) ? vpat[idx] : 1'b1;
                idx++;
                wasLast = resp_valid && (remaining == 1);
            end else begin
                resp_valid = 1'b0;
            end
            if (wasLast) lat = 0;
            tick();
            ticks++;
            if (lat >= 0) lat++;
            genCnt  += int'(gen_rst);
            lfsrCnt += int'(lfsr_en);
            finished = done;
        end
        resp_valid = 1'b0;
        checkOutput({tag, "_done"}, 32'(done), 32'd1);
        checkOutput({tag, "_pass"}, 32'(pass), 32'(expPass));
        checkOutput({tag, "_modelSig"}, 32'(msig), 32'(expSig));
        checkOutput({tag, "_genPulses"}, genCnt, 1);
        checkOutput({tag, "_lfsrCycles"}, lfsrCnt, expLfsr);
        checkOutput({tag, "_latency"}, (np > 0) ? lat : ticks, 2);
`ifdef MISR_SIG_OUT_EN
        checkOutput({tag, "_sig"}, 32'(signature), 32'(expSig));
`endif
        tick();
        tick();
        checkOutput({tag, "_held"}, 32'({done, pass}), 32'({1'b1, expPass}));
    endtask

    // Restart from DONE, abort mid-RUN with an asynchronous reset.
    task automatic resetMidRun();
        seed = 8'h3C; poly = 8'h1D; num_pat = CW'(10); golden = 8'h00;
        start = 1'b1;
        tick();
        checkOutput("restartGen", 32'(gen_rst), 32'd1);
        resp_valid = 1'b1;
        resp = 8'h5A;
        repeat (3) tick();
        checkOutput("preRstRun", 32'({lfsr_en, busy}), 32'b11);
        #1 rst = 1'b1;
        #1;
        checkOutput("asyncRstOuts", 32'(outVec()), 32'd0);
`ifdef MISR_SIG_OUT_EN
        checkOutput("asyncRstSig", 32'(signature), 32'd0);
`endif
        start = 1'b0;
        resp_valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        checkOutput("idleAfterRst", 32'(outVec()), 32'd0);
    endtask

    // Randomized session with random gaps, stray start pulses while busy,
    // and a golden that either tracks the model signature or is random.
    task automatic applyStimulus();
        int pct;
        bit match, finished;
        logic [N-1:0] gRand;
        seed    = N'($urandom);
        poly    = N'($urandom);
        num_pat = CW'($urandom_range(0, 12));
        pct     = int'($urandom_range(30, 100));
        match   = 1'($urandom_range(0, 1));
        gRand   = N'($urandom);
        golden  = gRand;
        start   = 1'b1;
        tick();
        start    = 1'b0;
        finished = 1'b0;
        for (int c = 0; c < 400 && !finished; c++) begin
            resp_valid = (int'($urandom_range(1, 100)) <= pct);
            resp       = N'($urandom);
            start      = ($urandom_range(0, 7) == 0);
            golden     = match ? msig : gRand;
            tick();
            finished = done;
        end
        start = 1'b0;
        resp_valid = 1'b0;
        if (!finished) checkOutput("sessionTimeout", 32'd0, 32'd1);
        repeat ($urandom_range(0, 3)) tick();
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0; resp_valid = 1'b0; num_pat = '0;
        poly = '0; seed = '0; golden = '0; resp = '0;
        tick();
        tick();
        checkOutput("resetOuts", 32'(outVec()), 32'd0);
        rst = 1'b0;
        tick();
        checkOutput("idleOuts", 32'(outVec()), 32'd0);

        runDirected("basicMatch", 8'h01, 8'h00, 1, 8'h80, 8'h00, 8'h01, 8'h80, 1'b1, 1);
        runDirected("basicMiss",  8'h01, 8'h00, 1, 8'h81, 8'h00, 8'h01, 8'h80, 1'b0, 1);
        runDirected("polyTaps",   8'h01, 8'h1D, 1, 8'h92, 8'h0F, 8'h01, 8'h92, 1'b1, 1);
        runDirected("gapped",     8'h01, 8'h00, 3, 8'h20, 8'h00, 8'h15, 8'h20, 1'b1, 5);
        runDirected("zeroPat",    8'hA5, 8'h00, 0, 8'hA5, 8'h00, 8'h00, 8'hA5, 1'b1, 0);
        resetMidRun();

        for (int s = 0; s < 40; s++) applyStimulus();

        $display("[TB] %0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
